// File: rtl/mul_digit_serial_core_if.sv
// Start/operand/result bundle for the digit-serial multiplier core.
// Latency: none, this file only groups wires.
// Backpressure: none. A start that arrives while the core is busy is dropped, not queued.
interface mul_digit_serial_core_if #(
  parameter int WIDTH = 128
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         select_line;
  logic               In_Busy;
  logic               Out_Busy;
  logic               Done;
  logic [2*WIDTH-1:0] C_Out;

  // Requester side: drives operands and the start strobe.
  modport master (
    output A, B, select_line, In_Busy,
    input  Out_Busy, Done, C_Out
  );

  // Core side.
  modport slave (
    input  A, B, select_line, In_Busy,
    output Out_Busy, Done, C_Out
  );
endinterface

// File: rtl/mul_digit_serial_core.sv
// Digit-serial integer / carry-less (unreduced GF(2)[x]) multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency: WIDTH/DIGIT cycles from the accepting edge to Done. A new start is accepted in the Done cycle.
// Backpressure: none. A start seen while RUN, or with an unknown opcode, is dropped.
module mul_digit_serial_core #(
  parameter int         WIDTH = 128,
  parameter int         DIGIT = 8,
  parameter logic [2:0] MUL   = 3'b001,
  parameter logic [2:0] CLMUL = 3'b010
) (
  input  logic                    clk,
  input  logic                    rst,
  mul_digit_serial_core_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PP_W  = WIDTH + DIGIT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               clmul_q, clmul_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] c_q, c_d;

  logic [DIGIT-1:0]   digit;
  logic [PP_W-1:0]    pp_mul;
  logic [PP_W-1:0]    pp_clmul;
  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] acc_next;
  logic               start_ok;

  // One Horner step: take the top digit of the shifted B copy and fold A*d into the accumulator.
  always_comb begin
    digit    = b_q[WIDTH-1 -: DIGIT];
    pp_mul   = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, digit};
    pp_clmul = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (digit[j]) begin
        pp_clmul = pp_clmul ^ ({{DIGIT{1'b0}}, a_q} << j);
      end
    end
    pp_ext            = '0;
    pp_ext[PP_W-1:0]  = clmul_q ? pp_clmul : pp_mul;
    acc_shift         = acc_q << DIGIT;
    acc_next          = clmul_q ? (acc_shift ^ pp_ext) : (acc_shift + pp_ext);
  end

  // Start is only honoured for the two known opcodes.
  always_comb begin
    start_ok = bus.In_Busy && ((bus.select_line == MUL) || (bus.select_line == CLMUL));
  end

  // Next-state logic: IDLE latches operands on a valid start, RUN iterates N times then publishes.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    clmul_d = clmul_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          a_d     = bus.A;
          b_d     = bus.B;
          clmul_d = (bus.select_line == CLMUL);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          c_d     = acc_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and clears the published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      clmul_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clmul_q <= clmul_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
    end
  end

  assign bus.Out_Busy = busy_q;
  assign bus.Done     = done_q;
  assign bus.C_Out    = c_q;

endmodule

// File: tb/tb_mul_digit_serial_core.sv
// Directed bench for mul_digit_serial_core at DIGIT = 8, 1 and 128 (units 0, 1, 2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task does its own comparisons.
module tb_mul_digit_serial_core;

  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_CLMUL = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] a_s    [3];
  logic [127:0] b_s    [3];
  logic [2:0]   sel_s  [3];
  logic         go_s   [3];
  logic         busy_s [3];
  logic         done_s [3];
  logic [255:0] c_s    [3];

  mul_digit_serial_core_if #(.WIDTH(128)) bus0 ();
  mul_digit_serial_core_if #(.WIDTH(128)) bus1 ();
  mul_digit_serial_core_if #(.WIDTH(128)) bus2 ();

  assign bus0.A = a_s[0];  assign bus0.B = b_s[0];  assign bus0.select_line = sel_s[0];  assign bus0.In_Busy = go_s[0];
  assign bus1.A = a_s[1];  assign bus1.B = b_s[1];  assign bus1.select_line = sel_s[1];  assign bus1.In_Busy = go_s[1];
  assign bus2.A = a_s[2];  assign bus2.B = b_s[2];  assign bus2.select_line = sel_s[2];  assign bus2.In_Busy = go_s[2];
  assign busy_s[0] = bus0.Out_Busy;  assign done_s[0] = bus0.Done;  assign c_s[0] = bus0.C_Out;
  assign busy_s[1] = bus1.Out_Busy;  assign done_s[1] = bus1.Done;  assign c_s[1] = bus1.C_Out;
  assign busy_s[2] = bus2.Out_Busy;  assign done_s[2] = bus2.Done;  assign c_s[2] = bus2.C_Out;

  mul_digit_serial_core #(.WIDTH(128), .DIGIT(8))   u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mul_digit_serial_core #(.WIDTH(128), .DIGIT(1))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mul_digit_serial_core #(.WIDTH(128), .DIGIT(128)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference: schoolbook product / LSB-first shift-and-xor.
  function automatic logic [255:0] ref_product(input logic [127:0] a, input logic [127:0] b, input bit cl);
    logic [255:0] r;
    if (!cl) begin
      r = {128'd0, a} * {128'd0, b};
    end else begin
      r = '0;
      for (int i = 0; i < 128; i++) begin
        if (b[i]) r = r ^ ({128'd0, a} << i);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start on unit u and observe the run until Done (bounded).
  task automatic run_op(input int u, input logic [127:0] a, input logic [127:0] b, input logic [2:0] op,
                        output logic [255:0] res, output int lat, output int busy_n,
                        output bit seen, output bit busy_at_done);
    a_s[u] = a; b_s[u] = b; sel_s[u] = op; go_s[u] = 1'b1;
    tick();
    go_s[u] = 1'b0;
    lat = 0; busy_n = 0; seen = 1'b0; res = '0; busy_at_done = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (busy_s[u]) busy_n++;
      tick();
      lat++;
      if (done_s[u]) begin
        seen = 1'b1;
        res = c_s[u];
        busy_at_done = busy_s[u];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      checks++; if (busy_s[u] !== 1'b0) begin errors++; $display("FAIL reset_busy unit%0d: got %b want 0", u, busy_s[u]); end
      checks++; if (done_s[u] !== 1'b0) begin errors++; $display("FAIL reset_done unit%0d: got %b want 0", u, done_s[u]); end
      checks++; if (c_s[u] !== 256'd0) begin errors++; $display("FAIL reset_cout unit%0d: got %h want 0", u, c_s[u]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul_small();
    logic [255:0] res; int lat, bn; bit seen, bad;
    run_op(0, 128'd3, 128'd5, OP_MUL, res, lat, bn, seen, bad);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mul_small_done: got %b want 1", seen); end
    checks++; if (res !== 256'd15) begin errors++; $display("FAIL mul_small_result: got %0d want 15", res); end
    checks++; if (lat != 16) begin errors++; $display("FAIL mul_small_latency: got %0d want 16", lat); end
    checks++; if (bn != 16) begin errors++; $display("FAIL mul_small_busy_cycles: got %0d want 16", bn); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mul_small_busy_at_done: got %b want 0", bad); end
  endtask

  task automatic test_clmul_small();
    logic [255:0] res; int lat, bn; bit seen, bad;
    run_op(0, 128'd3, 128'd3, OP_CLMUL, res, lat, bn, seen, bad);
    checks++; if (res !== 256'd5) begin errors++; $display("FAIL clmul_3x3: got %0d want 5", res); end
    run_op(0, 128'd3, 128'd3, OP_MUL, res, lat, bn, seen, bad);
    checks++; if (res !== 256'd9) begin errors++; $display("FAIL mul_3x3: got %0d want 9", res); end
  endtask

  task automatic test_all_ones();
    logic [255:0] res, alt; int lat, bn; bit seen, bad;
    logic [127:0] ones, hi_exp;
    ones   = '1;
    hi_exp = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    alt    = {128{2'b01}};
    run_op(0, ones, ones, OP_MUL, res, lat, bn, seen, bad);
    checks++; if (res[255:128] !== hi_exp) begin errors++; $display("FAIL mul_ones_hi: got %h want %h", res[255:128], hi_exp); end
    checks++; if (res[127:0] !== 128'd1) begin errors++; $display("FAIL mul_ones_lo: got %h want 1", res[127:0]); end
    run_op(0, ones, ones, OP_CLMUL, res, lat, bn, seen, bad);
    checks++; if (res !== alt) begin errors++; $display("FAIL clmul_ones: got %h want %h", res, alt); end
  endtask

  // A start pulsed mid-run and operand changes after acceptance must not disturb the result.
  task automatic test_ignore_busy();
    int lat; bit seen; logic [255:0] res; int stray;
    a_s[0] = 128'd3; b_s[0] = 128'd5; sel_s[0] = OP_MUL; go_s[0] = 1'b1;
    tick();
    go_s[0] = 1'b0;
    a_s[0] = 128'd77; b_s[0] = 128'd99; sel_s[0] = OP_CLMUL;
    lat = 0; seen = 1'b0; res = '0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (i == 5) begin a_s[0] = 128'd100; b_s[0] = 128'd100; sel_s[0] = OP_MUL; go_s[0] = 1'b1; end
      tick();
      go_s[0] = 1'b0;
      lat++;
      if (done_s[0]) begin seen = 1'b1; res = c_s[0]; end
    end
    checks++; if (res !== 256'd15) begin errors++; $display("FAIL ignore_busy_result: got %0d want 15", res); end
    checks++; if (lat != 16) begin errors++; $display("FAIL ignore_busy_latency: got %0d want 16", lat); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_s[0] || done_s[0]) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL ignore_busy_not_queued: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_bad_opcode();
    logic [2:0] ops [4];
    int stray;
    ops[0] = 3'b000; ops[1] = 3'b011; ops[2] = 3'b100; ops[3] = 3'b111;
    for (int k = 0; k < 4; k++) begin
      a_s[0] = 128'd5; b_s[0] = 128'd5; sel_s[0] = ops[k]; go_s[0] = 1'b1;
      tick();
      go_s[0] = 1'b0;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
        if (busy_s[0] || done_s[0]) stray++;
        tick();
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL bad_opcode_%0d_activity: got %0d active cycles want 0", k, stray); end
      checks++; if (c_s[0] !== 256'd15) begin errors++; $display("FAIL bad_opcode_%0d_cout: got %0d want 15", k, c_s[0]); end
    end
  endtask

  task automatic test_reset_abort();
    logic [255:0] res; int lat, bn, stray; bit seen, bad;
    a_s[0] = 128'd9; b_s[0] = 128'd9; sel_s[0] = OP_MUL; go_s[0] = 1'b1;
    tick();
    go_s[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (c_s[0] !== 256'd0) begin errors++; $display("FAIL abort_cout: got %0d want 0", c_s[0]); end
    checks++; if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_s[0]); end
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      if (done_s[0] || busy_s[0]) stray++;
      tick();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", stray); end
    // reset and start together: reset wins
    rst = 1'b1; a_s[0] = 128'd2; b_s[0] = 128'd2; sel_s[0] = OP_MUL; go_s[0] = 1'b1;
    tick();
    rst = 1'b0; go_s[0] = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_s[0] || busy_s[0]) stray++;
      tick();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_with_start: got %0d active cycles want 0", stray); end
    run_op(0, 128'd7, 128'd6, OP_MUL, res, lat, bn, seen, bad);
    checks++; if (res !== 256'd42) begin errors++; $display("FAIL after_abort_mul: got %0d want 42", res); end
    checks++; if (lat != 16) begin errors++; $display("FAIL after_abort_latency: got %0d want 16", lat); end
  endtask

  // Six operations chained so each start is presented in the previous Done cycle.
  task automatic test_back_to_back(input int u, input int n);
    logic [127:0] av [6];
    logic [127:0] bv [6];
    bit           cl [6];
    logic [255:0] exp_r;
    int lat; bit seen;
    for (int i = 0; i < 6; i++) begin
      av[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      bv[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      cl[i] = (i >= 3);
    end
    a_s[u] = av[0]; b_s[u] = bv[0]; sel_s[u] = OP_MUL; go_s[u] = 1'b1;
    tick();
    go_s[u] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lat = 0; seen = 1'b0;
      for (int c = 0; c < n + 10 && !seen; c++) begin
        tick();
        lat++;
        if (done_s[u]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL b2b_unit%0d_op%0d_timeout: no Done within %0d cycles", u, i, n + 10);
        break;
      end
      exp_r = ref_product(av[i], bv[i], cl[i]);
      checks++; if (lat != n) begin errors++; $display("FAIL b2b_unit%0d_op%0d_latency: got %0d want %0d", u, i, lat, n); end
      checks++; if (c_s[u] !== exp_r) begin errors++; $display("FAIL b2b_unit%0d_op%0d_result: got %h want %h", u, i, c_s[u], exp_r); end
      if (i < 5) begin
        a_s[u] = av[i+1]; b_s[u] = bv[i+1]; sel_s[u] = cl[i+1] ? OP_CLMUL : OP_MUL; go_s[u] = 1'b1;
        tick();
        go_s[u] = 1'b0;
        checks++; if (busy_s[u] !== 1'b1) begin errors++; $display("FAIL b2b_unit%0d_op%0d_accept_in_done: busy got %b want 1", u, i + 1, busy_s[u]); end
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      a_s[u] = '0; b_s[u] = '0; sel_s[u] = 3'b000; go_s[u] = 1'b0;
    end
    test_reset();
    test_mul_small();
    test_clmul_small();
    test_all_ones();
    test_mul_small();
    test_ignore_busy();
    test_bad_opcode();
    test_reset_abort();
    test_back_to_back(0, 16);
    test_back_to_back(1, 128);
    test_back_to_back(2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
